// File: rtl/sub2_rr_sched.sv
// Round-robin burst scheduler sharing one sub2 input lane between N_REQ requesters.
// One registered output stage drives sub2 sig_e/sig_f; grants rotate after each burst.

package my_pkg;
  typedef logic [7:0] my_t;
endpackage

package lib_pkg;
  typedef logic [3:0] our_t;
endpackage

module sub2_rr_sched
  import my_pkg::*;
#(
  parameter int N_REQ     = 3,
  parameter int MAX_BURST = 4,
  parameter int TIMEOUT   = 15
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [0:N_REQ-1]    req_valid,
  input  my_t  [0:N_REQ-1]    req_data,
  input  lib_pkg::our_t       req_tag [N_REQ],
  input  logic [0:N_REQ-1]    req_last,
  output logic [0:N_REQ-1]    req_ready,
  output logic                out_valid,
  input  logic                out_ready,
  output my_t                 out_data,
  output lib_pkg::our_t       out_tag,
  output logic [1:0]          out_src,
  output logic                busy,
  output logic                err_timeout
);

  localparam int BW = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
  localparam int WW = $clog2(TIMEOUT + 1);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] BUSY = 1'b1;

  logic [0:0]    state;
  logic [1:0]    owner;
  logic [1:0]    ptr;
  logic [BW-1:0] beat_cnt;
  logic [WW-1:0] wdog;

  logic [1:0] nxt_owner;
  logic [1:0] idx;
  logic       nxt_found;
  logic       stage_free;
  logic       own_valid;
  logic       take;
  logic       last_beat;
  logic       wdog_fire;

  // Rotating priority: scan starts just past the last owner.
  always_comb begin
    nxt_found = 1'b0;
    nxt_owner = ptr;
    idx       = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      idx = 2'((int'(ptr) + k) % N_REQ);
      if (!nxt_found && req_valid[idx]) begin
        nxt_found = 1'b1;
        nxt_owner = idx;
      end
    end
  end

  assign busy       = (state == BUSY);
  assign stage_free = !out_valid || out_ready;
  assign own_valid  = req_valid[owner];
  assign take       = busy && own_valid && stage_free;
  assign last_beat  = req_last[owner] || (beat_cnt == BW'(MAX_BURST - 1));
  assign wdog_fire  = (wdog == WW'(TIMEOUT - 1));

  for (genvar g = 0; g < N_REQ; g++) begin : g_ready
    assign req_ready[g] = busy && (owner == 2'(g)) && stage_free;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      owner       <= '0;
      ptr         <= 2'(N_REQ - 1);
      beat_cnt    <= '0;
      wdog        <= '0;
      out_valid   <= 1'b0;
      out_data    <= '0;
      out_tag     <= '0;
      out_src     <= '0;
      err_timeout <= 1'b0;
    end else begin
      err_timeout <= 1'b0;

      // Drain and refill in the same cycle keeps the stage full at 1 beat/cycle.
      if (take) begin
        out_valid <= 1'b1;
        out_data  <= req_data[owner];
        out_tag   <= req_tag[owner];
        out_src   <= owner;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end

      case (state)
        IDLE: begin
          if (nxt_found) begin
            state    <= BUSY;
            owner    <= nxt_owner;
            beat_cnt <= '0;
            wdog     <= '0;
          end
        end
        BUSY: begin
          if (take) begin
            wdog <= '0;
            if (last_beat) begin
              state    <= IDLE;
              ptr      <= owner;
              beat_cnt <= '0;
            end else begin
              beat_cnt <= beat_cnt + BW'(1);
            end
          end else if (!own_valid) begin
            // Only an absent owner ages the watchdog; backpressure does not.
            wdog <= wdog + WW'(1);
            if (wdog_fire) begin
              state       <= IDLE;
              ptr         <= owner;
              err_timeout <= 1'b1;
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sub2_rr_sched.sv
// Directed bench for sub2_rr_sched: arbitration order, burst limits, backpressure,
// watchdog release and asynchronous reset, checked against hand-computed values.

module tb_sub2_rr_sched;
  import my_pkg::*;
  import lib_pkg::*;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [0:2]    req_valid;
  my_t  [0:2]    req_data;
  our_t          req_tag [3];
  logic [0:2]    req_last;
  logic [0:2]    req_ready;
  logic          out_valid;
  logic          out_ready;
  my_t           out_data;
  our_t          out_tag;
  logic [1:0]    out_src;
  logic          busy;
  logic          err_timeout;

  int   errs = 0;
  int   checks = 0;
  int   sent [3];
  logic [0:2] acc;
  bit   auto_last, auto_data;

  always #5 clk = ~clk;

  sub2_rr_sched dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_data(req_data), .req_tag(req_tag),
    .req_last(req_last), .req_ready(req_ready),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_tag(out_tag), .out_src(out_src), .busy(busy), .err_timeout(err_timeout)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock: note handshakes before the edge, then let requesters react after it.
  task automatic cyc();
    @(negedge clk);
    for (int i = 0; i < 3; i++) acc[i] = req_valid[i] && req_ready[i];
    @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      if (acc[i]) begin
        sent[i]++;
        if (auto_data) req_data[i] = req_data[i] + 8'd1;
      end
      if (auto_last) req_last[i] = (sent[i] % 2 == 1);
    end
    #1;
  endtask

  task automatic hold_reset();
    @(posedge clk);
    #1;
    rst_n     = 1'b0;
    req_valid = '0;
    req_last  = '0;
    out_ready = 1'b1;
    auto_last = 1'b0;
    auto_data = 1'b0;
    for (int i = 0; i < 3; i++) begin
      sent[i]     = 0;
      req_data[i] = 8'h00;
      req_tag[i]  = our_t'(i + 1);
    end
  endtask

  task automatic release_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  int ev1 [9] = '{0, 1, 1, 0, 1, 1, 0, 1, 1};
  int eb1 [9] = '{1, 1, 0, 1, 1, 0, 1, 1, 0};
  int es1 [9] = '{0, 0, 0, 0, 1, 1, 0, 2, 2};
  int ed1 [9] = '{0, 'h11, 'h11, 0, 'h22, 'h22, 0, 'h33, 'h33};
  int ev2 [13] = '{0, 1, 1, 1, 1, 0, 1, 1, 1, 1, 0, 1, 1};
  int eb2 [13] = '{1, 1, 1, 1, 0, 1, 1, 1, 1, 0, 1, 1, 1};

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    rst_n = 1'b0;
    hold_reset();
    #3;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_req_ready", req_ready, 0);
    chk("rst_err", err_timeout, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_src", out_src, 0);

    // 1: all requesters valid, two-beat bursts, rotation 0,1,2 with a dead cycle between.
    req_valid = 3'b111;
    req_data[0] = 8'h11; req_data[1] = 8'h22; req_data[2] = 8'h33;
    auto_last = 1'b1;
    release_reset();
    for (int k = 0; k < 9; k++) begin
      cyc();
      chk("t1_valid", out_valid, ev1[k]);
      chk("t1_busy", busy, eb1[k]);
      if (ev1[k] != 0) begin
        chk("t1_src", out_src, es1[k]);
        chk("t1_data", out_data, ed1[k]);
        chk("t1_tag", out_tag, es1[k] + 1);
      end
    end

    // 2: requester 1 alone for 10 beats, no last: forced releases after 4 beats.
    hold_reset();
    req_valid[1] = 1'b1;
    req_data[1]  = 8'hA5;
    release_reset();
    for (int k = 0; k < 13; k++) begin
      cyc();
      if (sent[1] == 10) req_valid[1] = 1'b0;
      chk("t2_valid", out_valid, ev2[k]);
      chk("t2_busy", busy, eb2[k]);
      if (ev2[k] != 0) chk("t2_src", out_src, 1);
    end
    chk("t2_beats", sent[1], 10);

    // 3: requester 2 stalled by backpressure; data holds, no watchdog.
    hold_reset();
    req_valid[2] = 1'b1;
    req_data[2]  = 8'h50;
    auto_data    = 1'b1;
    release_reset();
    cyc();
    chk("t3_grant", req_ready, 3'b001);
    cyc();
    chk("t3_first", out_data, 'h50);
    out_ready = 1'b0;
    #1;
    chk("t3_stall_ready", req_ready[2], 0);
    for (int k = 0; k < 18; k++) begin
      cyc();
      chk("t3_hold_data", out_data, 'h50);
      chk("t3_hold_valid", out_valid, 1);
      chk("t3_hold_ready", req_ready[2], 0);
      chk("t3_no_err", err_timeout, 0);
    end
    out_ready = 1'b1;
    #1;
    chk("t3_resume_ready", req_ready[2], 1);
    cyc(); chk("t3_b1", out_data, 'h51);
    cyc(); chk("t3_b2", out_data, 'h52);
    cyc(); chk("t3_b3", out_data, 'h53);
    chk("t3_b3_valid", out_valid, 1);
    chk("t3_end_busy", busy, 0);

    // 4: owner 0 goes quiet after one beat; watchdog releases, pending 1 is granted.
    hold_reset();
    req_valid[0] = 1'b1;
    req_valid[1] = 1'b1;
    req_data[0]  = 8'h70;
    release_reset();
    cyc();
    chk("t4_grant0", req_ready, 3'b100);
    cyc();
    chk("t4_beat", out_data, 'h70);
    req_valid[0] = 1'b0;
    for (int k = 1; k <= 15; k++) begin
      cyc();
      if (k == 1) chk("t4_drained", out_valid, 0);
      if (k < 15) begin
        chk("t4_err_early", err_timeout, 0);
        chk("t4_busy_held", busy, 1);
      end else begin
        chk("t4_err_pulse", err_timeout, 1);
        chk("t4_released", busy, 0);
      end
    end
    cyc();
    chk("t4_err_clear", err_timeout, 0);
    chk("t4_grant1", req_ready, 3'b010);

    // 5: asynchronous reset mid-burst of requester 1, then priority back to 0.
    hold_reset();
    req_valid = 3'b111;
    req_data[0] = 8'h11; req_data[1] = 8'h22; req_data[2] = 8'h33;
    req_last[0] = 1'b1;
    release_reset();
    cyc();
    chk("t5_grant0", req_ready, 3'b100);
    cyc();
    chk("t5_single_src", out_src, 0);
    chk("t5_single_busy", busy, 0);
    cyc();
    chk("t5_grant1", req_ready, 3'b010);
    cyc();
    chk("t5_mid_valid", out_valid, 1);
    chk("t5_mid_src", out_src, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t5_async_valid", out_valid, 0);
    chk("t5_async_busy", busy, 0);
    chk("t5_async_ready", req_ready, 0);
    release_reset();
    cyc();
    chk("t5_regrant0", req_ready, 3'b100);

    // 6: requesters 0 and 2; after 0's burst, 2 wins and 1 is skipped.
    hold_reset();
    req_valid[0] = 1'b1;
    req_valid[2] = 1'b1;
    req_data[2]  = 8'h3C;
    req_last[0]  = 1'b1;
    release_reset();
    cyc();
    chk("t6_grant0", req_ready, 3'b100);
    cyc();
    chk("t6_src0", out_src, 0);
    chk("t6_idle", busy, 0);
    cyc();
    chk("t6_grant2", req_ready, 3'b001);
    cyc();
    chk("t6_src2", out_src, 2);
    chk("t6_data2", out_data, 'h3C);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
